// File: rtl/cont_one_hot_encoded_controller_pkg.sv
// rtl/cont_one_hot_encoded_controller_pkg.sv - state encodings, cp codes and cp lookup
package cont_one_hot_encoded_controller_pkg;

    typedef enum logic [6:0] {
        ST_ZERO = 7'b0000000,
        ST_A    = 7'b1000000,
        ST_B    = 7'b0100000,
        ST_C    = 7'b0010000,
        ST_D    = 7'b0001000,
        ST_E    = 7'b0000100,
        ST_F    = 7'b0000010,
        ST_G    = 7'b0000001
    } state_e;

    localparam logic [4:0] CP_ZERO = 5'b00000;
    localparam logic [4:0] CP_A    = 5'b00110;
    localparam logic [4:0] CP_B    = 5'b10101;
    localparam logic [4:0] CP_C    = 5'b01110;
    localparam logic [4:0] CP_D    = 5'b11001;
    localparam logic [4:0] CP_E    = 5'b01101;
    localparam logic [4:0] CP_F    = 5'b01000;
    localparam logic [4:0] CP_G    = 5'b10001;

    // Anything that is not one of the seven legal states maps to the all-zero word.
    function automatic logic [4:0] state_to_cp(input logic [6:0] state);
        logic [4:0] code;
        code = CP_ZERO;
        case (state)
            ST_A:    code = CP_A;
            ST_B:    code = CP_B;
            ST_C:    code = CP_C;
            ST_D:    code = CP_D;
            ST_E:    code = CP_E;
            ST_F:    code = CP_F;
            ST_G:    code = CP_G;
            default: code = CP_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cont_one_hot_encoded_controller_if.sv
// rtl/cont_one_hot_encoded_controller_if.sv - status/control bundle between datapath and sequencer
interface cont_one_hot_encoded_controller_if;
    logic       start;
    logic       V;
    logic       Z;
    logic [4:0] cp;
    logic [6:0] presState;

    modport master (output start, output V, output Z, input cp, input presState);
    modport slave  (input start, input V, input Z, output cp, output presState);
endinterface

// File: rtl/cont_ohe_next_state.sv
// rtl/cont_ohe_next_state.sv - combinational next-state logic holding the transition table
module cont_ohe_next_state
    import cont_one_hot_encoded_controller_pkg::*;
(
    input  logic [6:0] pres_state,
    input  logic       v,
    input  logic       z,
    input  logic       start,
    input  logic       clr,
    output state_e     next_state
);

    // Unknown flag values fall through to ST_ZERO so the sequencer parks safely.
    function automatic state_e pick(input logic [1:0] vz, input state_e s00, input state_e s01,
                                    input state_e s10, input state_e s11);
        state_e s;
        s = ST_ZERO;
        case (vz)
            2'b00:   s = s00;
            2'b01:   s = s01;
            2'b10:   s = s10;
            2'b11:   s = s11;
            default: s = ST_ZERO;
        endcase
        return s;
    endfunction

    logic [1:0] vz;

    always_comb begin
        next_state = ST_ZERO;
        vz         = {v, z};
        if (clr) begin
            next_state = ST_ZERO;
        end else if (start) begin
            next_state = ST_A;
        end else begin
            case (pres_state)
                ST_A:    next_state = pick(vz, ST_A, ST_C, ST_G, ST_D);
                ST_B:    next_state = pick(vz, ST_D, ST_A, ST_F, ST_A);
                ST_C:    next_state = pick(vz, ST_B, ST_C, ST_E, ST_D);
                ST_D:    next_state = pick(vz, ST_F, ST_G, ST_F, ST_A);
                ST_E:    next_state = pick(vz, ST_B, ST_E, ST_G, ST_B);
                ST_F:    next_state = pick(vz, ST_A, ST_B, ST_D, ST_E);
                ST_G:    next_state = pick(vz, ST_G, ST_F, ST_C, ST_E);
                // Zero state and any non-one-hot pattern wait for start.
                default: next_state = ST_ZERO;
            endcase
        end
    end

endmodule

// File: rtl/cont_one_hot_encoded_controller.sv
// rtl/cont_one_hot_encoded_controller.sv - one-hot Moore sequencer with registered cp word
module cont_one_hot_encoded_controller
    import cont_one_hot_encoded_controller_pkg::*;
(
    input  logic                           clk,
    input  logic                           clr,
    cont_one_hot_encoded_controller_if.slave bus
);

    logic [6:0] pres_state_q;
    logic [6:0] pres_state_d;
    logic [4:0] cp_q;
    logic [4:0] cp_d;
    state_e     next_state;

    cont_ohe_next_state u_next_state (
        .pres_state (pres_state_q),
        .v          (bus.V),
        .z          (bus.Z),
        .start      (bus.start),
        .clr        (clr),
        .next_state (next_state)
    );

    // cp is looked up from the next state so both registers update on the same edge.
    always_comb begin
        pres_state_d = next_state;
        cp_d         = state_to_cp(next_state);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pres_state_q <= ST_ZERO;
            cp_q         <= CP_ZERO;
        end else begin
            pres_state_q <= pres_state_d;
            cp_q         <= cp_d;
        end
    end

    assign bus.presState = pres_state_q;
    assign bus.cp        = cp_q;

endmodule

// File: tb/tb_cont_one_hot_encoded_controller.sv
// tb/tb_cont_one_hot_encoded_controller.sv - scoreboard bench with table-driven reference model
module tb_cont_one_hot_encoded_controller;

    typedef struct {
        logic [6:0] st;
        logic [4:0] cp;
        string      name;
    } exp_t;

    logic clk;
    logic clr;
    int   checks;
    int   failures;
    int   m;
    exp_t exp_q[$];

    // States indexed A=0 .. G=6; -1 is the zero state.
    int         nxt [7][4] = '{'{0,2,6,3}, '{3,0,5,0}, '{1,2,4,3}, '{5,6,5,0},
                               '{1,4,6,1}, '{0,1,3,4}, '{6,5,2,4}};
    logic [4:0] cps [7]    = '{5'b00110, 5'b10101, 5'b01110, 5'b11001,
                               5'b01101, 5'b01000, 5'b10001};
    int         plen[7]    = '{0, 2, 1, 1, 2, 2, 1};
    int         p0  [7]    = '{0, 1, 1, 3, 1, 3, 2};
    int         p1  [7]    = '{0, 0, 0, 0, 2, 0, 0};

    cont_one_hot_encoded_controller_if bus ();

    cont_one_hot_encoded_controller dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_out(input int idx, input string nm);
        exp_t e;
        logic [6:0] one;
        one    = 7'b1000000;
        e.name = nm;
        if (idx < 0) begin
            e.st = 7'b0;
            e.cp = 5'b0;
        end else begin
            e.st = one >> idx;
            e.cp = cps[idx];
        end
        return e;
    endfunction

    task automatic step(input logic c, input logic s, input logic v, input logic z, input string nm);
        @(negedge clk);
        clr       = c;
        bus.start = s;
        bus.V     = v;
        bus.Z     = z;
        if (c)          m = -1;
        else if (s)     m = 0;
        else if (m < 0) m = -1;
        else            m = nxt[m][int'({v, z})];
        exp_q.push_back(model_out(m, nm));
    endtask

    task automatic step_vz(input int vz, input string nm);
        logic [1:0] b;
        b = 2'(vz);
        step(1'b0, 1'b0, b[1], b[0], nm);
    endtask

    task automatic goto_state(input int s);
        step(1'b0, 1'b1, 1'($urandom), 1'($urandom), "enter_a");
        if (plen[s] > 0) step_vz(p0[s], "path");
        if (plen[s] > 1) step_vz(p1[s], "path");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.presState !== e.st || bus.cp !== e.cp) begin
                    failures++;
                    $display("FAIL %s: presState=%b cp=%b expected presState=%b cp=%b",
                             e.name, bus.presState, bus.cp, e.st, e.cp);
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        checks    = 0;
        failures  = 0;
        m         = -1;
        clr       = 1'b1;
        bus.start = 1'b0;
        bus.V     = 1'b0;
        bus.Z     = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), "reset");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), "zero_hold");

        step(1'b0, 1'b1, 1'b0, 1'b0, "start_a");
        step_vz(1, "a01_c");
        step_vz(0, "c00_b");
        step_vz(2, "b10_f");
        step_vz(3, "f11_e");

        for (int s = 0; s < 7; s++) begin
            for (int vz = 0; vz < 4; vz++) begin
                goto_state(s);
                step_vz(vz, "sweep");
            end
        end

        goto_state(0); for (int i = 0; i < 4; i++) step_vz(0, "loop_a");
        goto_state(2); for (int i = 0; i < 4; i++) step_vz(1, "loop_c");
        goto_state(4); for (int i = 0; i < 4; i++) step_vz(1, "loop_e");
        goto_state(6); for (int i = 0; i < 4; i++) step_vz(0, "loop_g");

        goto_state(3);
        step(1'b1, 1'b1, 1'($urandom), 1'($urandom), "clr_over_start");
        goto_state(6);
        step(1'b0, 1'b1, 1'b1, 1'b1, "start_over_vz");

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom), 1'($urandom), "random");

        goto_state(1);
        @(negedge clk);
        clr       = 1'b0;
        bus.start = 1'b0;
        force dut.pres_state_q = 7'b1100000;
        #1;
        release dut.pres_state_q;
        m = -1;
        exp_q.push_back(model_out(-1, "illegal_recover"));
        step(1'b0, 1'b0, 1'($urandom), 1'($urandom), "illegal_stay_zero");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d expected pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cont_one_hot_encoded_controller.md
Name: cont_one_hot_encoded_controller

Overview:
- Seven-state Moore control-unit sequencer with one-hot encoded state.
- Steered by two datapath status flags: V (overflow) and Z (zero).
- Emits a 5-bit control-point word (cp) to the datapath.
- Exposes the present one-hot state for debug and verification.

Parameters:
- None. State encodings and cp codes are fixed constants defined in the shared package.

Ports:
clk  input  1  rising-edge clock; all state changes occur on this edge
clr  input  1  synchronous active-high clear; highest priority
start  input  1  synchronous start; forces state A
V  input  1  overflow status flag
Z  input  1  zero status flag
cp  output  5  registered control-point word for the present state
presState  output  7  registered one-hot present state

Behaviour:
- Interface: one clock; reset (clr) is synchronous and active-high.
- All inputs are sampled on the rising edge of clk. presState and cp are both registers and change only on that edge (one-cycle latency from inputs to outputs).
- Priority on each edge is clr, then start, then the transition table.
- clr=1: presState <= 7'b0000000 and cp <= 5'b00000. This is the reset value of both outputs. A clear applied mid-operation is effective at the next edge regardless of start, V or Z.
- clr=0, start=1: presState <= A and cp <= 00110, from any present state including the zero state.
- Otherwise, next state is chosen by {V,Z}. Each row lists the next state for {V,Z} = 00, 01, 10, 11:
  - A: A, C, G, D
  - B: D, A, F, A
  - C: B, C, E, D
  - D: F, G, F, A
  - E: B, E, G, B
  - F: A, B, D, E
  - G: G, F, C, E
- State encodings: A=1000000, B=0100000, C=0010000, D=0001000, E=0000100, F=0000010, G=0000001.
- cp codes: A=00110, B=10101, C=01110, D=11001, E=01101, F=01000, G=10001.
- cp always equals the code of the registered presState. It is computed from the next state and registered in the same edge, so there is no skew between cp and presState.
- Zero state (after clr) with start=0: remain 0000000 with cp=00000. Only start leaves this state.
- Any non-one-hot or otherwise illegal presState with start=0: go to 0000000 with cp=00000 on the next edge.
- X/Z on V or Z while in a legal state: go to 0000000 with cp=00000.

Decomposition:
- Shared package holds:
  - the seven one-hot state constants (7-bit);
  - the seven cp code constants (5-bit);
  - a state-to-cp lookup function.
- Natural sub-module: cont_ohe_next_state. It is combinational, maps (presState, V, Z, start, clr) to next state, and encodes the transition table.
- The top level holds the two registers and the cp lookup.

Test Plan:
- clr=1 for 3 edges (V/Z/start toggling) -> presState=0000000, cp=00000 after the first edge; then clr=0, start=0 for 2 edges -> outputs stay zero.
- clr=0, start=1 for one edge -> presState=1000000, cp=00110. Then start=0, {V,Z}=01 -> 0010000/01110; {V,Z}=00 -> 0100000/10101; {V,Z}=10 -> 0000010/01000; {V,Z}=11 -> 0000100/01101.
- Full sweep of all 28 (state, {V,Z}) pairs, each entered via start plus a known path -> next state and cp match the table and codes every edge.
- Self-loops: A with 00, C with 01, E with 01, G with 00, each held for 4 edges -> state and cp stay constant.
- clr=1 and start=1 on the same edge while in D -> 0000000/00000. Then start=1 while in G -> 1000000/00110, with start taking precedence over V/Z.
- Force presState to an illegal value (e.g. 1100000) via a bench force, then release with start=0 -> next edge gives 0000000/00000.
